// File: rtl/biss_master.sv
// biss_master: BiSS-C style point-to-point master.
//
// A trigger in IDLE starts one frame. The master clock (biss_sck_o) runs
// until the slave acknowledges (data low) and sends its start bit (data
// high). The CDS bit is then skipped, BITS position bits are shifted in MSB
// first, followed by the nE/nW bits and an inverted 6-bit CRC. A matching
// CRC updates posn_o/nerr_o/nwarn_o with a one-cycle posn_valid_o strobe. A
// mismatch gives a crc_err_o strobe instead. After every frame, and after an
// ack/start timeout, the master holds the clock high until the slave has
// released the line (data high for two cycles).
//
// Ports:
//   clk_i         system clock, rising edge
//   reset_i       asynchronous active-low reset
//   BITS          position width, clamped to 1..48 at frame start
//   CLK_DIV       clk_i cycles per sck half period, minimum 2
//   trigger_i     single-cycle frame request
//   biss_dat_i    slave SLO line (asynchronous)
//   biss_sck_o    master MA clock, idles high
//   posn_o        last good position, right-aligned, zero-extended
//   posn_valid_o  one-cycle strobe when posn_o updates
//   nerr_o        slave nE bit captured with posn_o
//   nwarn_o       slave nW bit captured with posn_o
//   crc_err_o     one-cycle CRC mismatch strobe
//   ack_err_o     one-cycle ack/start timeout strobe
//   busy_o        high from accepted trigger until return to IDLE
module biss_master (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  BITS,
  input  logic [15:0] CLK_DIV,
  input  logic        trigger_i,
  input  logic        biss_dat_i,
  output logic        biss_sck_o,
  output logic [47:0] posn_o,
  output logic        posn_valid_o,
  output logic        nerr_o,
  output logic        nwarn_o,
  output logic        crc_err_o,
  output logic        ack_err_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACK     = 3'd1,
    S_START   = 3'd2,
    S_CDS     = 3'd3,
    S_DATA    = 3'd4,
    S_ERRWARN = 3'd5,
    S_CRC     = 3'd6,
    S_TIMEOUT = 3'd7
  } state_t;

  // One serial step of the x^6 + x + 1 CRC (MSB first).
  function automatic logic [5:0] crc6_step(input logic [5:0] crc, input logic din);
    logic fb;
    fb = crc[5] ^ din;
    return {crc[4:0], 1'b0} ^ (fb ? 6'h03 : 6'h00);
  endfunction

  function automatic logic [5:0] clamp_bits(input logic [7:0] b);
    logic [5:0] r;
    if (b == 8'd0) begin
      r = 6'd1;
    end else if (b > 8'd48) begin
      r = 6'd48;
    end else begin
      r = b[5:0];
    end
    return r;
  endfunction

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    logic [15:0] r;
    if (d < 16'd2) begin
      r = 16'd2;
    end else begin
      r = d;
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic        dat_meta_q, dat_sync_q;
  logic        sck_q, sck_d;
  logic [15:0] div_q, div_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [5:0]  bits_q, bits_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [5:0]  per_cnt_q, per_cnt_d;
  logic        hi_q, hi_d;
  logic [47:0] shift_q, shift_d;
  logic [1:0]  ew_q, ew_d;
  logic [5:0]  crc_q, crc_d;
  logic [5:0]  rx_crc_q, rx_crc_d;
  logic        check_q, check_d;
  logic [47:0] posn_q, posn_d;
  logic        nerr_q, nerr_d;
  logic        nwarn_q, nwarn_d;
  logic        valid_q, valid_d;
  logic        crc_err_q, crc_err_d;
  logic        ack_err_q, ack_err_d;
  logic        busy_q, busy_d;

  logic        running_s;
  logic        half_done_s;
  logic        rise_s;

  // Two-flop synchroniser for the asynchronous slave data line.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      dat_meta_q <= 1'b0;
      dat_sync_q <= 1'b0;
    end else begin
      dat_meta_q <= biss_dat_i;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign running_s   = (state_q != S_IDLE) && (state_q != S_TIMEOUT);
  assign half_done_s = (div_cnt_q == (div_q - 16'd1));
  // The bit is sampled on the same edge that drives sck high.
  assign rise_s      = running_s && !sck_q && half_done_s;

  // Next-state, clock divider, shifter and CRC logic.
  always_comb begin
    state_d   = state_q;
    sck_d     = sck_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    bits_d    = bits_q;
    bit_cnt_d = bit_cnt_q;
    per_cnt_d = per_cnt_q;
    hi_d      = hi_q;
    shift_d   = shift_q;
    ew_d      = ew_q;
    crc_d     = crc_q;
    rx_crc_d  = rx_crc_q;
    check_d   = 1'b0;
    posn_d    = posn_q;
    nerr_d    = nerr_q;
    nwarn_d   = nwarn_q;
    valid_d   = 1'b0;
    crc_err_d = 1'b0;
    ack_err_d = 1'b0;

    if (running_s) begin
      if (half_done_s) begin
        div_cnt_d = 16'd0;
        sck_d     = ~sck_q;
      end else begin
        div_cnt_d = div_cnt_q + 16'd1;
      end
    end else begin
      div_cnt_d = 16'd0;
      sck_d     = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (trigger_i && dat_sync_q) begin
          state_d   = S_ACK;
          sck_d     = 1'b0;
          div_cnt_d = 16'd0;
          div_d     = clamp_div(CLK_DIV);
          bits_d    = clamp_bits(BITS);
          bit_cnt_d = 6'd0;
          per_cnt_d = 6'd0;
          shift_d   = 48'd0;
          ew_d      = 2'b00;
          crc_d     = 6'd0;
          rx_crc_d  = 6'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        if (rise_s) begin
          if (!dat_sync_q) begin
            state_d   = S_START;
            per_cnt_d = 6'd0;
          end else if (per_cnt_q == 6'd63) begin
            ack_err_d = 1'b1;
            state_d   = S_TIMEOUT;
            hi_d      = 1'b0;
          end else begin
            per_cnt_d = per_cnt_q + 6'd1;
          end
        end else begin
          state_d = S_ACK;
        end
      end
      S_START: begin
        if (rise_s) begin
          if (dat_sync_q) begin
            state_d = S_CDS;
          end else if (per_cnt_q == 6'd63) begin
            ack_err_d = 1'b1;
            state_d   = S_TIMEOUT;
            hi_d      = 1'b0;
          end else begin
            per_cnt_d = per_cnt_q + 6'd1;
          end
        end else begin
          state_d = S_START;
        end
      end
      S_CDS: begin
        if (rise_s) begin
          state_d   = S_DATA;
          bit_cnt_d = 6'd0;
        end else begin
          state_d = S_CDS;
        end
      end
      S_DATA: begin
        if (rise_s) begin
          shift_d = {shift_q[46:0], dat_sync_q};
          crc_d   = crc6_step(crc_q, dat_sync_q);
          if (bit_cnt_q == (bits_q - 6'd1)) begin
            state_d   = S_ERRWARN;
            bit_cnt_d = 6'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_ERRWARN: begin
        // ew_q[1] ends up holding nE, ew_q[0] holds nW.
        if (rise_s) begin
          ew_d  = {ew_q[0], dat_sync_q};
          crc_d = crc6_step(crc_q, dat_sync_q);
          if (bit_cnt_q == 6'd1) begin
            state_d   = S_CRC;
            bit_cnt_d = 6'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end else begin
          state_d = S_ERRWARN;
        end
      end
      S_CRC: begin
        // The last CRC bit lands on an sck rising edge, so the clock is
        // already high when the frame moves on to wait for line release.
        if (rise_s) begin
          rx_crc_d = {rx_crc_q[4:0], dat_sync_q};
          if (bit_cnt_q == 6'd5) begin
            check_d = 1'b1;
            state_d = S_TIMEOUT;
            hi_d    = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end else begin
          state_d = S_CRC;
        end
      end
      S_TIMEOUT: begin
        if (dat_sync_q) begin
          if (hi_q) begin
            state_d = S_IDLE;
            hi_d    = 1'b0;
          end else begin
            hi_d = 1'b1;
          end
        end else begin
          hi_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The slave sends its CRC inverted; compare one cycle after the last bit.
    if (check_q) begin
      if (crc_q == ~rx_crc_q) begin
        posn_d  = shift_q;
        nerr_d  = ew_q[1];
        nwarn_d = ew_q[0];
        valid_d = 1'b1;
      end else begin
        crc_err_d = 1'b1;
      end
    end else begin
      valid_d   = 1'b0;
      crc_err_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      sck_q     <= 1'b1;
      div_q     <= 16'd2;
      div_cnt_q <= 16'd0;
      bits_q    <= 6'd1;
      bit_cnt_q <= 6'd0;
      per_cnt_q <= 6'd0;
      hi_q      <= 1'b0;
      shift_q   <= 48'd0;
      ew_q      <= 2'b11;
      crc_q     <= 6'd0;
      rx_crc_q  <= 6'd0;
      check_q   <= 1'b0;
      posn_q    <= 48'd0;
      nerr_q    <= 1'b1;
      nwarn_q   <= 1'b1;
      valid_q   <= 1'b0;
      crc_err_q <= 1'b0;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sck_q     <= sck_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      bits_q    <= bits_d;
      bit_cnt_q <= bit_cnt_d;
      per_cnt_q <= per_cnt_d;
      hi_q      <= hi_d;
      shift_q   <= shift_d;
      ew_q      <= ew_d;
      crc_q     <= crc_d;
      rx_crc_q  <= rx_crc_d;
      check_q   <= check_d;
      posn_q    <= posn_d;
      nerr_q    <= nerr_d;
      nwarn_q   <= nwarn_d;
      valid_q   <= valid_d;
      crc_err_q <= crc_err_d;
      ack_err_q <= ack_err_d;
      busy_q    <= busy_d;
    end
  end

  assign biss_sck_o   = sck_q;
  assign posn_o       = posn_q;
  assign posn_valid_o = valid_q;
  assign nerr_o       = nerr_q;
  assign nwarn_o      = nwarn_q;
  assign crc_err_o    = crc_err_q;
  assign ack_err_o    = ack_err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_biss_master.sv
// Self-checking bench for biss_master: table of directed frames plus
// hand-written sequences for timeouts, repeated triggers and mid-frame reset.
module tb_biss_master;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [7:0]  BITS;
  logic [15:0] CLK_DIV;
  logic        trigger_i;
  logic        biss_dat_i;
  logic        biss_sck_o;
  logic [47:0] posn_o;
  logic        posn_valid_o, nerr_o, nwarn_o, crc_err_o, ack_err_o, busy_o;

  int total = 0;
  int bad   = 0;

  int   cyc = 0;
  int   rises = 0, lo_run = 0, lo_min = 0, lo_max = 0, last_rise = 0;
  int   vcnt = 0, vcyc = 0, ccnt = 0, ccyc = 0, acnt = 0;
  logic sck_prev = 1'b1;

  typedef struct {
    logic [7:0]  bits;
    logic [15:0] div;
    int          nb;
    int          eff_div;
    logic [47:0] data;
    logic        ne;
    logic        nw;
    logic        flip;
    logic        xtrig;
    logic [47:0] exp_posn;
    logic        exp_valid;
    logic        exp_nerr;
    logic        exp_nwarn;
  } vec_t;

  vec_t vecs[7];

  biss_master dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .BITS         (BITS),
    .CLK_DIV      (CLK_DIV),
    .trigger_i    (trigger_i),
    .biss_dat_i   (biss_dat_i),
    .biss_sck_o   (biss_sck_o),
    .posn_o       (posn_o),
    .posn_valid_o (posn_valid_o),
    .nerr_o       (nerr_o),
    .nwarn_o      (nwarn_o),
    .crc_err_o    (crc_err_o),
    .ack_err_o    (ack_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Observe sck periods, low-phase widths and strobes away from the active edge.
  always @(negedge clk_i) begin
    cyc = cyc + 1;
    if (biss_sck_o && !sck_prev) begin
      rises = rises + 1;
      last_rise = cyc;
      if (lo_run < lo_min) lo_min = lo_run;
      if (lo_run > lo_max) lo_max = lo_run;
      lo_run = 0;
    end else if (!biss_sck_o) begin
      lo_run = lo_run + 1;
    end
    if (posn_valid_o) begin vcnt = vcnt + 1; vcyc = cyc; end
    if (crc_err_o)    begin ccnt = ccnt + 1; ccyc = cyc; end
    if (ack_err_o)    acnt = acnt + 1;
    sck_prev = biss_sck_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    rises = 0; lo_run = 0; lo_min = 100000; lo_max = 0;
    vcnt = 0; ccnt = 0; acnt = 0; vcyc = 0; ccyc = 0; last_rise = 0;
  endtask

  task automatic pulse_trig();
    @(posedge clk_i); #1 trigger_i = 1'b1;
    @(posedge clk_i); #1 trigger_i = 1'b0;
  endtask

  task automatic wait_rise(output bit ok);
    logic p;
    p  = biss_sck_o;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_i); #1;
      if (!p && biss_sck_o) begin
        ok = 1'b1;
        break;
      end
      p = biss_sck_o;
    end
  endtask

  // Reference CRC by polynomial long division of msg * x^6 by x^6+x+1.
  function automatic logic [5:0] crc_ref(input logic [55:0] msg, input int n);
    logic [69:0] w;
    w = {14'd0, msg} << 6;
    for (int i = n + 5; i >= 6; i--) begin
      if (w[i]) w[i -: 7] = w[i -: 7] ^ 7'b1000011;
    end
    return w[5:0];
  endfunction

  // Drive one complete frame as the slave and check the result.
  task automatic run_vec(input vec_t v, input int idx);
    logic        st[0:63];
    logic [5:0]  c;
    logic [55:0] msg;
    bit          ok;
    int          lat;
    for (int i = 0; i < 64; i++) st[i] = 1'b1;
    msg = ({8'd0, v.data} << 2) | {54'd0, v.ne, v.nw};
    c = crc_ref(msg, v.nb + 2);
    st[1] = 1'b0; st[2] = 1'b1; st[3] = 1'b0;
    for (int i = 0; i < v.nb; i++) st[4 + i] = v.data[v.nb - 1 - i];
    st[4 + v.nb] = v.ne;
    st[5 + v.nb] = v.nw;
    for (int k = 0; k < 6; k++) st[6 + v.nb + k] = ~c[5 - k];
    if (v.flip) st[11 + v.nb] = ~st[11 + v.nb];

    clr();
    BITS = v.bits; CLK_DIV = v.div; biss_dat_i = 1'b1;
    pulse_trig();
    chk($sformatf("v%0d_first_low", idx), 64'(biss_sck_o), 64'd0);
    chk($sformatf("v%0d_busy", idx), 64'(busy_o), 64'd1);
    for (int r = 1; r <= v.nb + 11; r++) begin
      wait_rise(ok);
      if (!ok) begin
        chk($sformatf("v%0d_rise_wait", idx), 64'd0, 64'd1);
        break;
      end
      biss_dat_i = st[r];
      if (v.xtrig && (r == 10 || r == 20)) pulse_trig();
    end
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_i); #1;
      if (vcnt + ccnt > 0) break;
    end
    repeat (10) @(posedge clk_i);
    #1;
    chk($sformatf("v%0d_posn", idx), 64'(posn_o), 64'(v.exp_posn));
    chk($sformatf("v%0d_valid_cnt", idx), 64'(vcnt), 64'(v.exp_valid));
    chk($sformatf("v%0d_crcerr_cnt", idx), 64'(ccnt), 64'(!v.exp_valid));
    chk($sformatf("v%0d_ackerr_cnt", idx), 64'(acnt), 64'd0);
    chk($sformatf("v%0d_nerr", idx), 64'(nerr_o), 64'(v.exp_nerr));
    chk($sformatf("v%0d_nwarn", idx), 64'(nwarn_o), 64'(v.exp_nwarn));
    chk($sformatf("v%0d_periods", idx), 64'(rises), 64'(v.nb + 12));
    chk($sformatf("v%0d_lo_min", idx), 64'(lo_min), 64'(v.eff_div));
    chk($sformatf("v%0d_lo_max", idx), 64'(lo_max), 64'(v.eff_div));
    lat = (v.exp_valid ? vcyc : ccyc) - last_rise;
    chk($sformatf("v%0d_latency", idx), 64'(lat), 64'd1);
    chk($sformatf("v%0d_sck_hold", idx), 64'(biss_sck_o), 64'd1);
    // Slave releases the line: low a few cycles, then high.
    biss_dat_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 biss_dat_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      if (!busy_o) break;
    end
    chk($sformatf("v%0d_busy_clear", idx), 64'(busy_o), 64'd0);
  endtask

  initial begin
    bit ok;
    vecs[0] = '{8'd19, 16'd4, 19, 4, 48'h5A5A5, 1'b1, 1'b1, 1'b0, 1'b0, 48'h5A5A5, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{8'd19, 16'd4, 19, 4, 48'h5A5A5, 1'b1, 1'b1, 1'b1, 1'b0, 48'h5A5A5, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{8'd48, 16'd4, 48, 4, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'd8, 16'd2, 8, 2, 48'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 48'hA5, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'd1, 16'd0, 1, 2, 48'h1, 1'b1, 1'b1, 1'b0, 1'b0, 48'h1, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{8'd0, 16'd1, 1, 2, 48'h0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'd60, 16'd3, 48, 3, 48'h1234_5678_9ABC, 1'b1, 1'b1, 1'b0, 1'b0, 48'h1234_5678_9ABC, 1'b1, 1'b1, 1'b1};

    reset_i = 1'b0; trigger_i = 1'b0; biss_dat_i = 1'b1;
    BITS = 8'd19; CLK_DIV = 16'd4;
    clr();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_sck", 64'(biss_sck_o), 64'd1);
    chk("rst_posn", 64'(posn_o), 64'd0);
    chk("rst_nerr", 64'(nerr_o), 64'd1);
    chk("rst_nwarn", 64'(nwarn_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_strobes", 64'({posn_valid_o, crc_err_o, ack_err_o}), 64'd0);
    reset_i = 1'b1;
    repeat (5) @(posedge clk_i);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Slave never acknowledges: data stays high through ACK.
    clr();
    BITS = 8'd19; CLK_DIV = 16'd4; biss_dat_i = 1'b1;
    pulse_trig();
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk_i); #1;
      if (acnt > 0) break;
    end
    chk("ackto_sck", 64'(biss_sck_o), 64'd1);
    repeat (10) @(posedge clk_i);
    #1;
    chk("ackto_cnt", 64'(acnt), 64'd1);
    chk("ackto_periods", 64'(rises), 64'd64);
    chk("ackto_busy_clear", 64'(busy_o), 64'd0);
    chk("ackto_no_frame", 64'(vcnt + ccnt), 64'd0);

    // Slave acks but never sends a start bit: timeout in START, line held low.
    clr();
    pulse_trig();
    biss_dat_i = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk_i); #1;
      if (acnt > 0) break;
    end
    repeat (10) @(posedge clk_i);
    #1;
    chk("startto_cnt", 64'(acnt), 64'd1);
    chk("startto_periods", 64'(rises), 64'd65);
    chk("startto_busy_held", 64'(busy_o), 64'd1);
    chk("startto_sck", 64'(biss_sck_o), 64'd1);
    biss_dat_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      if (!busy_o) break;
    end
    chk("startto_busy_clear", 64'(busy_o), 64'd0);

    // Reset during DATA aborts the frame without strobes.
    clr();
    BITS = 8'd19; CLK_DIV = 16'd4; biss_dat_i = 1'b1;
    pulse_trig();
    for (int r = 1; r <= 8; r++) begin
      wait_rise(ok);
      if (!ok) begin
        chk("rstmid_rise_wait", 64'd0, 64'd1);
        break;
      end
      biss_dat_i = (r == 1 || r == 3) ? 1'b0 : 1'b1;
    end
    @(posedge clk_i);
    #1 reset_i = 1'b0; biss_dat_i = 1'b1;
    #1;
    chk("rstmid_sck", 64'(biss_sck_o), 64'd1);
    chk("rstmid_posn", 64'(posn_o), 64'd0);
    chk("rstmid_nerr", 64'(nerr_o), 64'd1);
    chk("rstmid_busy", 64'(busy_o), 64'd0);
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b1;
    repeat (30) @(posedge clk_i);
    #1;
    chk("rstmid_no_strobe", 64'(vcnt + ccnt + acnt), 64'd0);
    chk("rstmid_no_restart", 64'(busy_o), 64'd0);
    run_vec(vecs[0], 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/biss_master.md
BISS_MASTER -- requirements
Module: biss_master

Interface
REQ-001 Parameter-style inputs: BITS, 8 bit, no default, position data width per frame (values 1..48); CLK_DIV, 16 bit, no default, clk_i cycles per half period of biss_sck_o.
REQ-002 clk_i  in  1  system clock; all logic on rising edge.
REQ-003 reset_i  in  1  asynchronous, active-low reset.
REQ-004 BITS  in  8  position width.
REQ-005 CLK_DIV  in  16  half-period divider.
REQ-006 trigger_i  in  1  single-cycle frame request.
REQ-007 biss_dat_i  in  1  slave SLO data line, asynchronous.
REQ-008 biss_sck_o  out  1  master MA clock; idles high.
REQ-009 posn_o  out  48  last good position, right-aligned, zero-extended.
REQ-010 posn_valid_o  out  1  one-cycle strobe on posn_o update.
REQ-011 nerr_o / nwarn_o  out  1 each  slave nE/nW bits captured with posn_o.
REQ-012 crc_err_o / ack_err_o  out  1 each  one-cycle failure strobes.
REQ-013 busy_o  out  1  high from accepted trigger until return to IDLE.

Function
REQ-014 biss_dat_i SHALL pass through a 2-flop synchroniser before use; latency budget excludes line-delay compensation.
REQ-015 CLK_DIV values below 2 SHALL be treated as 2; BITS 0 treated as 1, above 48 treated as 48, sampled at frame start.
REQ-016 Frame SHALL start only on trigger_i in IDLE with synchronised data high; triggers at other times ignored, no queuing.
REQ-017 Each sck period SHALL be low CLK_DIV cycles then high CLK_DIV cycles; first low edge one clk after trigger accepted.
REQ-018 Data SHALL be sampled on the clk_i cycle that biss_sck_o rises.
REQ-019 States: IDLE, ACK, START, CDS, DATA, ERRWARN, CRC, TIMEOUT.
REQ-020 ACK: clock runs until sampled data low, then START; if no low sample within 64 sck periods, pulse ack_err_o, go TIMEOUT.
REQ-021 START: wait for sampled high (start bit), same 64-period limit and ack_err_o; then CDS.
REQ-022 CDS: consume one bit, discarded; then DATA.
REQ-023 DATA: shift exactly BITS bits MSB first; then ERRWARN shifts nE then nW; then CRC shifts 6 bits MSB first.
REQ-024 CRC SHALL be polynomial x^6+x^1+1, seed 0, over DATA and ERRWARN bits; received CRC is transmitted inverted and compared after inversion.
REQ-025 On match: posn_o, nerr_o, nwarn_o update and posn_valid_o pulses on the same cycle, one clk after last CRC sample.
REQ-026 On mismatch: outputs hold, crc_err_o pulses in that cycle.
REQ-027 TIMEOUT: biss_sck_o held high; return to IDLE when sampled data high for 2 consecutive clk_i cycles.
REQ-028 biss_sck_o SHALL never glitch and SHALL be high in IDLE and TIMEOUT.

Reset
REQ-029 While reset_i low: biss_sck_o=1, posn_o=0, nerr_o=nwarn_o=1, all strobes=0, busy_o=0, state IDLE, counters and CRC cleared.
REQ-030 Reset mid-frame SHALL abort immediately with no strobe; first post-reset frame requires a fresh trigger_i.

Verification
REQ-031 BITS=19, CLK_DIV=4, slave model sends 0x5A5A5, nE=nW=1, correct CRC -> posn_o=0x00000005A5A5, posn_valid_o single pulse, crc_err_o=0, 19+12 sck periods observed.
REQ-032 Same frame, one CRC bit flipped -> crc_err_o single pulse, posn_o unchanged, posn_valid_o=0.
REQ-033 Slave holds data high -> ack_err_o after 64 sck periods, biss_sck_o high, busy_o clears once data high.
REQ-034 trigger_i repeated mid-frame -> exactly one frame, one posn_valid_o.
REQ-035 reset_i asserted during DATA -> biss_sck_o=1, posn_o=0 within reset, no strobes; next trigger completes normally.
REQ-036 BITS=48, data all ones, nE=0 -> posn_o=0xFFFFFFFFFFFF, nerr_o=0, crc_err_o=0.
